// File: rtl/conv_pkg.sv
// Shared types and helpers for the serial 2-D convolution engine.
// Holds the FSM encoding, mode constants and flat-bus index arithmetic.
package conv_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_MAC  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    localparam logic MODE_CONV = 1'b0;
    localparam logic MODE_CORR = 1'b1;

    function automatic int clog2(input int value);
        int r;
        for (r = 0; (1 << r) < value; r++) begin
        end
        return r;
    endfunction

    // Element (row, col) of a square side x side array packed LSB-first.
    function automatic int flat_idx(input int row, input int col, input int side);
        return row * side + col;
    endfunction

endpackage

// File: rtl/conv2d_serial_engine_mac_pe.sv
// Single accumulating processing element: acc += pixel * weight when enabled.
// The raw product is exported so the owner can form the final sum without a second multiplier.
module mac_pe #(
    parameter int DATA_W = 8,
    parameter int ACC_W  = 20
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                clr,
    input  logic                en,
    input  logic [DATA_W-1:0]   pixel,
    input  logic [DATA_W-1:0]   weight,
    output logic [ACC_W-1:0]    acc,
    output logic [2*DATA_W-1:0] prod
);

    assign prod = pixel * weight;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst || clr) begin
            acc <= '0;
        end else if (en) begin
            acc <= acc + ACC_W'(prod);
        end
    end

endmodule

// File: rtl/conv2d_serial_engine.sv
// Serial valid-mode 2-D convolution/correlation: one kernel tap per cycle across
// an OUT_N x OUT_N array of MAC PEs, with snapshot inputs and saturating output.
module conv2d_serial_engine
    import conv_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int IMG_N  = 4,
    parameter int KER_K  = 3,
    parameter int OUT_W  = 8,
    parameter int ACC_W  = 20,
    localparam int OUT_N = IMG_N - KER_K + 1
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             start,
    input  logic                             mode,
    input  logic [IMG_N*IMG_N*DATA_W-1:0]    a_in,
    input  logic [KER_K*KER_K*DATA_W-1:0]    b_in,
    output logic                             busy,
    output logic                             done,
    output logic [OUT_N*OUT_N*OUT_W-1:0]     c_out,
    output logic                             ovf
);

    localparam int TAPS  = KER_K * KER_K;
    localparam int NPE   = OUT_N * OUT_N;
    localparam int TAP_W = (TAPS > 1) ? clog2(TAPS) : 1;
    localparam logic [TAP_W-1:0] TAP_LAST = TAP_W'(TAPS - 1);
    localparam logic [ACC_W-1:0] SAT_MAX  = ACC_W'({OUT_W{1'b1}});

    state_t state_q, state_d;
    logic [TAP_W-1:0]               tap_q;
    logic [IMG_N*IMG_N*DATA_W-1:0]  a_q;
    logic [TAPS*DATA_W-1:0]         b_q;
    logic                           mode_q;
    logic [NPE*OUT_W-1:0]           c_q, c_d;
    logic                           ovf_q, ovf_d;
    logic                           last_tap;
    int                             tap_i, tap_j;
    logic [DATA_W-1:0]              weight;
    logic [ACC_W-1:0]               acc  [NPE];
    logic [2*DATA_W-1:0]            prod [NPE];

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start) state_d = S_LOAD;
            S_LOAD:  state_d = S_MAC;
            S_MAC:   if (tap_q == TAP_LAST) state_d = S_DONE;
            S_DONE:  state_d = start ? S_LOAD : S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    assign busy     = (state_q == S_LOAD) || (state_q == S_MAC);
    assign done     = (state_q == S_DONE);
    assign last_tap = (state_q == S_MAC) && (tap_q == TAP_LAST);

    // NOTE: snapshot registers are reset too, so an aborted run leaves no stale operands behind.
    always_ff @(posedge clk) begin
        if (!rst) begin
            a_q    <= '0;
            b_q    <= '0;
            mode_q <= MODE_CONV;
            tap_q  <= '0;
        end else if (state_q == S_LOAD) begin
            a_q    <= a_in;
            b_q    <= b_in;
            mode_q <= mode;
            tap_q  <= '0;
        end else if ((state_q == S_MAC) && (tap_q != TAP_LAST)) begin
            tap_q  <= tap_q + TAP_W'(1);
        end
    end

    always_comb begin
        tap_i  = int'(tap_q) / KER_K;
        tap_j  = int'(tap_q) % KER_K;
        weight = b_q[int'(tap_q)*DATA_W +: DATA_W];
    end

    for (genvar r = 0; r < OUT_N; r++) begin : g_row
        for (genvar c = 0; c < OUT_N; c++) begin : g_col
            localparam int E = r * OUT_N + c;
            logic [DATA_W-1:0] pixel;

            // Convolution walks the image window backwards instead of flipping the kernel.
            always_comb begin
                if (mode_q == MODE_CORR) begin
                    pixel = a_q[flat_idx(r + tap_i, c + tap_j, IMG_N)*DATA_W +: DATA_W];
                end else begin
                    pixel = a_q[flat_idx(r + KER_K - 1 - tap_i, c + KER_K - 1 - tap_j, IMG_N)*DATA_W +: DATA_W];
                end
            end

            mac_pe #(
                .DATA_W (DATA_W),
                .ACC_W  (ACC_W)
            ) u_pe (
                .clk    (clk),
                .rst    (rst),
                .clr    (state_q == S_LOAD),
                .en     (state_q == S_MAC),
                .pixel  (pixel),
                .weight (weight),
                .acc    (acc[E]),
                .prod   (prod[E])
            );
        end
    end

    // Result is formed from the final tap's sum so c_out is valid while done is high.
    always_comb begin
        logic [ACC_W-1:0] fin;
        c_d   = '0;
        ovf_d = 1'b0;
        fin   = '0;
        for (int e = 0; e < NPE; e++) begin
            fin = acc[e] + ACC_W'(prod[e]);
            if (fin > SAT_MAX) begin
                c_d[e*OUT_W +: OUT_W] = '1;
                ovf_d = 1'b1;
            end else begin
                c_d[e*OUT_W +: OUT_W] = fin[OUT_W-1:0];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            c_q   <= '0;
            ovf_q <= 1'b0;
        end else if (last_tap) begin
            c_q   <= c_d;
            ovf_q <= ovf_d;
        end
    end

    assign c_out = c_q;
    assign ovf   = ovf_q;

endmodule
